// File: rtl/if_id_queue_pkg.sv
// Shared definitions for the IF->ID queue: bus-width defaults, bubble word and
// the push/pop operation encoding used by the pointer bookkeeping.
package if_id_queue_pkg;

    localparam int unsigned INST_ADDR_BUS = 32;
    localparam int unsigned INST_DATA_BUS = 32;
    localparam int unsigned SIDE_BUS      = 4;
    localparam logic        RST_ENABLE    = 1'b1;
    localparam logic [31:0] ZEROWORD      = 32'h0000_0000;

    typedef enum logic [1:0] {
        OpIdle = 2'b00,
        OpPush = 2'b01,
        OpPop  = 2'b10,
        OpBoth = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/if_id_queue_fifo_ptr.sv
// Pointer and occupancy bookkeeping for a power-of-two FIFO; storage lives in the
// instantiating module so the same block can serve the MEM-side queue.
module if_id_queue_fifo_ptr
    import if_id_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            clr_i,
    output logic [PtrW-1:0] wr_ptr_o,
    output logic [PtrW-1:0] rd_ptr_o,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            empty_o
);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);

    // Guard locally so a careless caller can never over/underflow the count.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            unique case (fifo_op(push_ok, pop_ok))
                OpPush: begin
                    wr_ptr_d = wr_ptr_q + PtrW'(1);
                    count_d  = count_q + CntW'(1);
                end
                OpPop: begin
                    rd_ptr_d = rd_ptr_q + PtrW'(1);
                    count_d  = count_q - CntW'(1);
                end
                OpBoth: begin
                    wr_ptr_d = wr_ptr_q + PtrW'(1);
                    rd_ptr_d = rd_ptr_q + PtrW'(1);
                end
                OpIdle: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i == RST_ENABLE) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;

endmodule

// File: rtl/if_id_queue.sv
// IF->ID boundary FIFO of {side, inst, pc}; lets IF fetch ahead while ID stalls and
// presents an all-zero bubble to ID when empty.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned ADDR_W = INST_ADDR_BUS,
    parameter int unsigned DATA_W = INST_DATA_BUS,
    parameter int unsigned SIDE_W = SIDE_BUS,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AFULL  = 3,
    localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              if_valid_i,
    output logic              if_ready_o,
    input  logic [ADDR_W-1:0] if_pc_i,
    input  logic [DATA_W-1:0] if_inst_i,
    input  logic [SIDE_W-1:0] if_side_i,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [DATA_W-1:0] id_inst_o,
    output logic [SIDE_W-1:0] id_side_o,
    output logic [CntW-1:0]   count_o,
    output logic              almost_full_o
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned EntryW = SIDE_W + DATA_W + ADDR_W;

    logic [EntryW-1:0] mem_q [DEPTH];
    logic [EntryW-1:0] head;
    logic [PtrW-1:0]   wr_ptr, rd_ptr;
    logic              full, empty;
    logic              push, pop;

    // Handshakes: if_ready is purely ~full, so a full queue never pushes on a pop cycle.
    assign push = if_valid_i & ~full & ~flush_i;
    assign pop  = ~empty & id_ready_i & ~flush_i;

    if_id_queue_fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_fifo_ptr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (push),
        .pop_i    (pop),
        .clr_i    (flush_i),
        .wr_ptr_o (wr_ptr),
        .rd_ptr_o (rd_ptr),
        .count_o  (count_o),
        .full_o   (full),
        .empty_o  (empty)
    );

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr] <= {if_side_i, if_inst_i, if_pc_i};
        end
    end

    assign head = mem_q[rd_ptr];

    always_comb begin
        id_pc_o   = ADDR_W'(ZEROWORD);
        id_inst_o = DATA_W'(ZEROWORD);
        id_side_o = '0;
        if (!empty) begin
            {id_side_o, id_inst_o, id_pc_o} = head;
        end
    end

    assign if_ready_o    = ~full;
    assign id_valid_o    = ~empty;
    assign almost_full_o = (count_o >= CntW'(AFULL));

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue with a queue-based scoreboard of expected entries.
module tb_if_id_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AFULL = 3;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [3:0]  side;
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst, flush, if_valid, id_ready;
    logic            if_ready, id_valid, almost_full;
    logic [31:0]     if_pc, if_inst, id_pc, id_inst;
    logic [3:0]      if_side, id_side;
    logic [CntW-1:0] count;

    ent_t exp_q[$];
    int   vectors = 0;
    int   misses  = 0;

    always #5 clk = ~clk;

    if_id_queue #(
        .ADDR_W (32),
        .DATA_W (32),
        .SIDE_W (4),
        .DEPTH  (DEPTH),
        .AFULL  (AFULL)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .if_valid_i    (if_valid),
        .if_ready_o    (if_ready),
        .if_pc_i       (if_pc),
        .if_inst_i     (if_inst),
        .if_side_i     (if_side),
        .id_valid_o    (id_valid),
        .id_ready_i    (id_ready),
        .id_pc_o       (id_pc),
        .id_inst_o     (id_inst),
        .id_side_o     (id_side),
        .count_o       (count),
        .almost_full_o (almost_full)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            misses++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        if_valid = v;
        if_pc    = pc;
        if_inst  = pc ^ 32'hA5A5_0000;
        if_side  = pc[5:2];
    endtask

    // Compare outputs against the model, advance the model, then clock once.
    task automatic cycle(input bit do_chk);
        ent_t h;
        bit   do_push, do_pop;
        int   sz;
        sz = exp_q.size();
        h  = (sz != 0) ? exp_q[0] : '0;
        if (do_chk) begin
            check("id_valid",    64'(id_valid),    64'(sz != 0));
            check("id_pc",       64'(id_pc),       64'(h.pc));
            check("id_inst",     64'(id_inst),     64'(h.inst));
            check("id_side",     64'(id_side),     64'(h.side));
            check("count",       64'(count),       64'(sz));
            check("if_ready",    64'(if_ready),    64'(sz < DEPTH));
            check("almost_full", 64'(almost_full), 64'(sz >= AFULL));
        end
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            do_pop  = (sz != 0) && id_ready;
            do_push = if_valid && (sz < DEPTH);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back('{side: if_side, inst: if_inst, pc: if_pc});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        id_ready = 1'b0;
        drive(1'b1, 32'h0000_0F00);
        @(negedge clk);

        // Reset held two cycles with if_valid asserted.
        cycle(1'b0);
        cycle(1'b1);
        rst = 1'b0;
        drive(1'b0, 32'h0);
        check("rst_id_pc", 64'(id_pc), 64'h0);
        check("rst_if_ready", 64'(if_ready), 64'h1);

        // Fill with ID stalled; fifth push must be dropped.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h1000 + 32'(4 * i));
            cycle(1'b1);
        end
        drive(1'b0, 32'h0);
        check("fill_count", 64'(count), 64'd4);
        check("fill_if_ready", 64'(if_ready), 64'h0);
        check("fill_afull", 64'(almost_full), 64'h1);
        id_ready = 1'b1;
        repeat (5) cycle(1'b1);
        check("drain_id_pc", 64'(id_pc), 64'h0);

        // Streaming: count holds at 1, pointers wrap several times.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h4000 + 32'(4 * i));
            cycle(1'b1);
        end
        drive(1'b0, 32'h0);
        check("stream_count", 64'(count), 64'd1);
        cycle(1'b1);

        // Full with pop: pop only, push accepted on the next cycle.
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h5000 + 32'(4 * i));
            cycle(1'b1);
        end
        id_ready = 1'b1;
        drive(1'b1, 32'h5010);
        cycle(1'b1);
        check("fullpop_count", 64'(count), 64'd3);
        cycle(1'b1);
        id_ready = 1'b0;
        drive(1'b0, 32'h0);
        check("fullpop_next", 64'(count), 64'd3);

        // Flush drops queue and same-cycle input.
        flush = 1'b1;
        drive(1'b1, 32'h2000);
        cycle(1'b1);
        flush = 1'b0;
        check("flush_count", 64'(count), 64'd0);
        check("flush_inst", 64'(id_inst), 64'h0);
        drive(1'b1, 32'h2004);
        cycle(1'b1);
        drive(1'b0, 32'h0);
        check("flush_head", 64'(id_pc), 64'h2004);

        // Mid-operation reset with push+pop in the same cycle.
        drive(1'b1, 32'h6000);
        cycle(1'b1);
        check("pre_rst_count", 64'(count), 64'd2);
        rst      = 1'b1;
        id_ready = 1'b1;
        drive(1'b1, 32'h6004);
        cycle(1'b1);
        rst      = 1'b0;
        id_ready = 1'b0;
        check("midrst_count", 64'(count), 64'd0);
        drive(1'b1, 32'h6008);
        cycle(1'b1);
        drive(1'b0, 32'h0);
        check("midrst_head", 64'(id_pc), 64'h6008);
        id_ready = 1'b1;
        repeat (2) cycle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
